// File: rtl/memory_access_if.sv
// Shared pipeline-state types and the data-memory port bundle for the memory stage.
package Mem_pkg;

  typedef enum logic [1:0] {
    MNONE = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } mem_op_e;

  typedef enum logic [1:0] {
    WbNone = 2'd0,
    WbAlu  = 2'd1,
    WbLoad = 2'd2,
    WbPc   = 2'd3
  } wb_op_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    wb_op_e      wb_op;
    mem_op_e     mem_op;
  } state_t;

endpackage

// Valid/ready data-memory port: request channel plus load-response channel.
interface memory_access_if;
  logic        dmem_req_valid_out;
  logic        dmem_req_ready_in;
  logic [31:0] dmem_addr_out;
  logic        dmem_write_out;
  logic [31:0] dmem_wdata_out;
  logic [3:0]  dmem_wmask_out;
  logic        dmem_resp_valid_in;
  logic [31:0] dmem_rdata_in;

  modport master (
    output dmem_req_valid_out, dmem_addr_out, dmem_write_out, dmem_wdata_out, dmem_wmask_out,
    input  dmem_req_ready_in, dmem_resp_valid_in, dmem_rdata_in
  );

  modport slave (
    input  dmem_req_valid_out, dmem_addr_out, dmem_write_out, dmem_wdata_out, dmem_wmask_out,
    output dmem_req_ready_in, dmem_resp_valid_in, dmem_rdata_in
  );
endinterface

// File: rtl/memory_access.sv
// Memory pipeline stage: issues loads/stores over a valid/ready port, stalls upstream while
// an access is in flight and registers state, ALU result and right-aligned load data.
module memory_access
  import Mem_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  state_t                 state_in,
  input  logic [31:0]            alu_result_in,
  input  logic [31:0]            store_data_in,
  output logic                   stall_out,
  memory_access_if.master        dmem,
  output state_t                 state_out,
  output logic [31:0]            alu_result_out,
  output logic [31:0]            mem_data_out,
  output logic                   misalign_out
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} fsm_e;

  fsm_e        fsm_q, fsm_d;
  state_t      lat_state_q, lat_state_d;
  logic [31:0] lat_addr_q, lat_addr_d;
  logic [31:0] lat_sd_q, lat_sd_d;
  state_t      state_out_q, state_out_d;
  logic [31:0] alu_out_q, alu_out_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        misalign_q, misalign_d;

  logic        in_misaligned;
  logic [4:0]  rd_shamt;

  // Halfword needs addr[0]==0, word needs addr[1:0]==0; bytes are always aligned.
  always_comb begin
    in_misaligned = 1'b0;
    if (state_in.funct3[1:0] == 2'd1) begin
      in_misaligned = alu_result_in[0];
    end else if (state_in.funct3[1:0] == 2'd2) begin
      in_misaligned = (alu_result_in[1:0] != 2'b00);
    end
  end

  assign rd_shamt = {lat_addr_q[1:0], 3'b000};

  // State register and pipeline output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm_q       <= StIdle;
      lat_state_q <= '0;
      lat_addr_q  <= '0;
      lat_sd_q    <= '0;
      state_out_q <= '0;
      alu_out_q   <= '0;
      mem_data_q  <= '0;
      misalign_q  <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      lat_state_q <= lat_state_d;
      lat_addr_q  <= lat_addr_d;
      lat_sd_q    <= lat_sd_d;
      state_out_q <= state_out_d;
      alu_out_q   <= alu_out_d;
      mem_data_q  <= mem_data_d;
      misalign_q  <= misalign_d;
    end
  end

  // Next-state logic; the default output is a bubble (all-zero state).
  always_comb begin
    fsm_d       = fsm_q;
    lat_state_d = lat_state_q;
    lat_addr_d  = lat_addr_q;
    lat_sd_d    = lat_sd_q;
    state_out_d = '0;
    alu_out_d   = alu_out_q;
    mem_data_d  = mem_data_q;
    misalign_d  = 1'b0;
    unique case (fsm_q)
      StIdle: begin
        if (state_in.valid) begin
          if (state_in.mem_op == MNONE) begin
            state_out_d = state_in;
            alu_out_d   = alu_result_in;
            mem_data_d  = '0;
          end else if (in_misaligned) begin
            // Killed access: pass the state along invalidated and flag it.
            state_out_d       = state_in;
            state_out_d.valid = 1'b0;
            misalign_d        = 1'b1;
          end else begin
            lat_state_d = state_in;
            lat_addr_d  = alu_result_in;
            lat_sd_d    = store_data_in;
            fsm_d       = StReq;
          end
        end
      end
      StReq: begin
        if (dmem.dmem_req_ready_in) begin
          if (lat_state_q.mem_op == STORE) begin
            state_out_d       = lat_state_q;
            state_out_d.valid = 1'b1;
            alu_out_d         = lat_addr_q;
            mem_data_d        = '0;
            fsm_d             = StIdle;
          end else begin
            fsm_d = StWait;
          end
        end
      end
      StWait: begin
        if (dmem.dmem_resp_valid_in) begin
          state_out_d       = lat_state_q;
          state_out_d.valid = 1'b1;
          alu_out_d         = lat_addr_q;
          mem_data_d        = dmem.dmem_rdata_in >> rd_shamt;
          fsm_d             = StIdle;
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  // Store lane steering from the latched address and access size.
  always_comb begin
    dmem.dmem_wmask_out = 4'b0000;
    dmem.dmem_wdata_out = lat_sd_q;
    if (lat_state_q.mem_op == STORE) begin
      case (lat_state_q.funct3[1:0])
        2'd0: begin
          dmem.dmem_wmask_out = 4'b0001 << lat_addr_q[1:0];
          dmem.dmem_wdata_out = {4{lat_sd_q[7:0]}};
        end
        2'd1: begin
          dmem.dmem_wmask_out = 4'b0011 << lat_addr_q[1:0];
          dmem.dmem_wdata_out = {2{lat_sd_q[15:0]}};
        end
        default: begin
          dmem.dmem_wmask_out = 4'b1111;
          dmem.dmem_wdata_out = lat_sd_q;
        end
      endcase
    end
  end

  assign stall_out               = (fsm_q != StIdle);
  assign dmem.dmem_req_valid_out = (fsm_q == StReq);
  assign dmem.dmem_addr_out      = {lat_addr_q[31:2], 2'b00};
  assign dmem.dmem_write_out     = (lat_state_q.mem_op == STORE);

  assign state_out      = state_out_q;
  assign alu_result_out = alu_out_q;
  assign mem_data_out   = mem_data_q;
  assign misalign_out   = misalign_q;

endmodule
